xor_stream_cipher: RTL
======================

Name: xor_stream_cipher

Overview:
Parametrised successor to the fixed 8-bit-key / 64-bit-message serial XOR encryptor. It takes a key and a message bit-serially and encrypts the message one key-width chunk per cycle, in either repeating-key or rolling-key mode. It then shifts the ciphertext out serially with a qualifying flag. It sits behind the TT pin wrapper in place of the separate deserializer / xor_encrypt / serialize chain.

Parameters:
MSG_WIDTH, 64, message/ciphertext length in bits; must be a multiple of KEY_WIDTH (elaboration-time check, fatal otherwise)
KEY_WIDTH, 8, key length in bits and encryption chunk size; 2..32
NCHUNK, MSG_WIDTH/KEY_WIDTH, derived localparam; not overridable

Ports:
iClk  in  1  system clock, all logic on rising edge
iRst  in  1  synchronous reset, active-high
iEn  in  1  clock enable; low freezes all state and outputs
iSerial_in  in  1  serial data, MSB first
iLoad_key  in  1  shift iSerial_in into key register this cycle
iLoad_msg  in  1  shift iSerial_in into message register this cycle
iMode  in  1  0 = repeating key, 1 = rolling key; sampled on the last message bit
oSerial_out  out  1  ciphertext bit, MSB first
oSerial_flag  out  1  high exactly when oSerial_out is valid
oKey_valid  out  1  KEY_WIDTH key bits received since reset
oBusy  out  1  high in ENCRYPT and SHIFT_OUT
oDone  out  1  one-cycle pulse after the last ciphertext bit
oError  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (iRst=1 at edge, regardless of iEn): state IDLE. All outputs 0. Key, message and ciphertext registers 0. All counters 0. Latched mode 0.
- iEn=0: no state, counter or output changes. Pulses (oDone, oError) are held rather than repeated.
- FSM states: IDLE -> ENCRYPT -> SHIFT_OUT -> DONE -> IDLE.
- IDLE, iLoad_key=1:
  - key <= {key[KEY_WIDTH-2:0], iSerial_in}.
  - Key counter saturates at KEY_WIDTH; oKey_valid is set when it reaches KEY_WIDTH.
  - Extra bits keep shifting, so the last KEY_WIDTH bits win.
- IDLE, iLoad_msg=1 and iLoad_key=0:
  - Shift into the message register the same way; message counter increments.
  - Deasserting iLoad_msg mid-message holds the counter; resuming continues the load.
- On the bit that brings the message counter to MSG_WIDTH:
  - If oKey_valid: latch iMode, go to ENCRYPT next cycle, clear the chunk index.
  - Otherwise: pulse oError, clear the message counter, stay in IDLE.
- iLoad_key and iLoad_msg both high: key shift only, message ignored, oError pulses.
- ENCRYPT: one chunk per cycle for NCHUNK cycles.
  - Chunk i is msg[MSG_WIDTH-1-i*KEY_WIDTH -: KEY_WIDTH], i=0 is the MSB chunk.
  - It is XORed with keystream k_i and written to the same slice of the ciphertext register.
  - Keystream: k_0 = key. Mode 0: k_{i+1} = k_i. Mode 1: k_{i+1} = rotate-left-by-1(k_i). The stored key is never modified.
- SHIFT_OUT: MSG_WIDTH cycles.
  - oSerial_out = ciphertext MSB, then shift left; oSerial_flag=1 in each of these cycles.
  - oSerial_out=0 and oSerial_flag=0 at all other times.
- DONE: oDone=1 for one cycle. Message counter cleared; key and oKey_valid retained. Return to IDLE.
- Latency: last message bit sampled at edge T.
  - ENCRYPT covers cycles T+1..T+NCHUNK.
  - Serial bits are valid in cycles T+NCHUNK+1..T+NCHUNK+MSG_WIDTH.
  - oDone is high in cycle T+NCHUNK+MSG_WIDTH+1.
- oBusy=1: iLoad_key and iLoad_msg are ignored. Either one asserted pulses oError once per busy episode; the operation continues unaffected.
- iMode changes after the latch point have no effect on the current message.
- Reset mid-ENCRYPT or mid-SHIFT_OUT: immediate return to reset values. oSerial_flag drops in the same cycle and no oDone is issued.

Decomposition:
- Package xor_cipher_pkg holds:
  - the state enum (ST_IDLE, ST_ENCRYPT, ST_SHIFT_OUT, ST_DONE);
  - mode constants MODE_REPEAT=0 and MODE_ROLL=1;
  - a rotl function parameterised by width.
- One sub-module, xor_keystream_gen: holds k_i, loads the key on entry to ENCRYPT, and advances per chunk according to the latched mode.
- Counters, FSM and shift registers stay in xor_stream_cipher.

Test Plan:
- Defaults, mode 0: key 0xA5, message 0x0123456789ABCDEF -> serial out 0xA486E0C22C0E684A. Exactly 64 flag cycles starting 9 cycles after the last message bit; oDone one cycle after the last bit.
- Same key and message, mode 1 -> 0xA468D34AD31FA43D.
- 64-bit message load with no key loaded -> oError pulse on the 64th bit, no oBusy, oSerial_flag stays 0; a subsequent key plus message load encrypts normally.
- iEn toggled low for 3 cycles in the middle of SHIFT_OUT -> output bit and flag frozen, ciphertext unchanged; total flagged bits still 64.
- iRst asserted at serial bit 20 -> all outputs 0 next cycle, oKey_valid=0, no oDone; a full reload encrypts correctly.
- MSG_WIDTH=32, KEY_WIDTH=16, mode 1: key 0x8001, message 0x12345678 -> keystream 0x8001, 0x0003; ciphertext 0x9235567B.

Source files
------------

// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types, mode constants and rotate helper for the XOR stream cipher
package xor_cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCRYPT,
    ST_SHIFT_OUT,
    ST_DONE
  } state_t;

  localparam logic MODE_REPEAT = 1'b0;
  localparam logic MODE_ROLL   = 1'b1;

  localparam int MAX_KEY_WIDTH = 32;

  // Rotate the low 'width' bits of v left by one; bits at and above 'width' come back zero.
  function automatic logic [MAX_KEY_WIDTH-1:0] rotl(input logic [MAX_KEY_WIDTH-1:0] v,
                                                    input int unsigned width);
    logic [MAX_KEY_WIDTH-1:0] mask;
    mask = (width >= MAX_KEY_WIDTH) ? '1
         : ((MAX_KEY_WIDTH'(1) << width) - MAX_KEY_WIDTH'(1));
    return ((v << 1) | (v >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/xor_keystream_gen.sv
// rtl/xor_keystream_gen.sv - per-chunk keystream word, repeating or rolling from the stored key
module xor_keystream_gen
  import xor_cipher_pkg::*;
#(
  parameter int KEY_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic                 advance,
  input  logic                 mode,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [KEY_WIDTH-1:0] ks
);

  logic [KEY_WIDTH-1:0] ks_rot;

  assign ks_rot = KEY_WIDTH'(rotl(MAX_KEY_WIDTH'(ks), KEY_WIDTH));

  // Copy the key at the start of a message, then step once per encrypted chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ks <= '0;
    end else if (en) begin
      if (load) begin
        ks <= key;
      end else if (advance && (mode == MODE_ROLL)) begin
        ks <= ks_rot;
      end
    end
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - serial-in, chunked XOR encrypt, serial-out cipher core
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int MSG_WIDTH = 64,
  parameter int KEY_WIDTH = 8
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iSerial_in,
  input  logic iLoad_key,
  input  logic iLoad_msg,
  input  logic iMode,
  output logic oSerial_out,
  output logic oSerial_flag,
  output logic oKey_valid,
  output logic oBusy,
  output logic oDone,
  output logic oError
);

  localparam int NCHUNK = MSG_WIDTH / KEY_WIDTH;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BIT_W  = $clog2(MSG_WIDTH);
  localparam int MCNT_W = $clog2(MSG_WIDTH + 1);
  localparam int KCNT_W = $clog2(KEY_WIDTH + 1);

  generate
    if (((MSG_WIDTH % KEY_WIDTH) != 0) || (KEY_WIDTH < 2) || (KEY_WIDTH > MAX_KEY_WIDTH)) begin : g_bad_params
      $fatal(1, "xor_stream_cipher: MSG_WIDTH must be a multiple of KEY_WIDTH, KEY_WIDTH in 2..32");
    end
  endgenerate

  state_t                state, state_next;
  logic [KEY_WIDTH-1:0]  key_q;
  logic [MSG_WIDTH-1:0]  msg_q;
  logic [MSG_WIDTH-1:0]  ct_q;
  logic [KCNT_W-1:0]     key_cnt;
  logic [MCNT_W-1:0]     msg_cnt;
  logic [CIDX_W-1:0]     chunk_idx;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      chunk_base;
  logic                  mode_q;
  logic                  key_valid;
  logic                  err_q;
  logic                  busy_err_seen;
  logic [KEY_WIDTH-1:0]  ks;

  logic busy, key_shift, msg_shift, msg_last, start, busy_viol, err_set;

  // MSB bit position of the chunk being encrypted this cycle.
  assign chunk_base = BIT_W'(MSG_WIDTH - 1 - int'(chunk_idx) * KEY_WIDTH);

  xor_keystream_gen #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_ks (
    .clk    (iClk),
    .rst    (iRst),
    .en     (iEn),
    .load   (start),
    .advance(state == ST_ENCRYPT),
    .mode   (mode_q),
    .key    (key_q),
    .ks     (ks)
  );

  // Next-state decode, load qualification, protocol checks and registered-state outputs.
  always_comb begin
    state_next   = state;
    busy         = (state == ST_ENCRYPT) || (state == ST_SHIFT_OUT);
    key_shift    = (state == ST_IDLE) && iLoad_key;
    msg_shift    = (state == ST_IDLE) && iLoad_msg && !iLoad_key;
    msg_last     = msg_shift && (msg_cnt == MCNT_W'(MSG_WIDTH - 1));
    start        = msg_last && key_valid;
    busy_viol    = busy && (iLoad_key || iLoad_msg);
    err_set      = ((state == ST_IDLE) && iLoad_key && iLoad_msg)
                 || (msg_last && !key_valid)
                 || (busy_viol && !busy_err_seen);
    oSerial_flag = (state == ST_SHIFT_OUT);
    oSerial_out  = (state == ST_SHIFT_OUT) && ct_q[MSG_WIDTH-1];
    oKey_valid   = key_valid;
    oBusy        = busy;
    oDone        = (state == ST_DONE);
    oError       = err_q;
    case (state)
      ST_IDLE:      if (start) state_next = ST_ENCRYPT;
      ST_ENCRYPT:   if (chunk_idx == CIDX_W'(NCHUNK - 1)) state_next = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (bit_cnt == BIT_W'(MSG_WIDTH - 1)) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // State register; a low enable freezes the sequence in place.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else if (iEn) begin
      state <= state_next;
    end
  end

  // Shift registers, counters, mode latch and the one-shot error flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      key_q         <= '0;
      msg_q         <= '0;
      ct_q          <= '0;
      key_cnt       <= '0;
      msg_cnt       <= '0;
      chunk_idx     <= '0;
      bit_cnt       <= '0;
      mode_q        <= MODE_REPEAT;
      key_valid     <= 1'b0;
      err_q         <= 1'b0;
      busy_err_seen <= 1'b0;
    end else if (iEn) begin
      err_q         <= err_set;
      busy_err_seen <= busy ? (busy_err_seen | busy_viol) : 1'b0;

      if (key_shift) begin
        key_q <= {key_q[KEY_WIDTH-2:0], iSerial_in};
        if (key_cnt != KCNT_W'(KEY_WIDTH)) key_cnt <= key_cnt + KCNT_W'(1);
        if (key_cnt >= KCNT_W'(KEY_WIDTH - 1)) key_valid <= 1'b1;
      end

      if (msg_shift) begin
        msg_q <= {msg_q[MSG_WIDTH-2:0], iSerial_in};
        if (msg_last && !key_valid) msg_cnt <= '0;
        else                        msg_cnt <= msg_cnt + MCNT_W'(1);
        if (start) begin
          mode_q    <= iMode;
          chunk_idx <= '0;
          bit_cnt   <= '0;
        end
      end

      case (state)
        ST_ENCRYPT: begin
          ct_q[chunk_base -: KEY_WIDTH] <= msg_q[chunk_base -: KEY_WIDTH] ^ ks;
          chunk_idx <= chunk_idx + CIDX_W'(1);
        end
        ST_SHIFT_OUT: begin
          ct_q    <= {ct_q[MSG_WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
        ST_DONE: msg_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
